// File: rtl/demux_1to4_buf.sv
// demux_1to4_buf: steers one input word per cycle into one of four
// independent 2-entry FIFOs, each drained on its own valid/ready pair.
// Optional per-channel accept counters are built when DEMUX_STATS_EN is defined.
module demux_1to4_buf #(
  parameter int unsigned size = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [size-1:0] in_data,
  input  logic [1:0]      in_select,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [size-1:0] out0,
  output logic [size-1:0] out1,
  output logic [size-1:0] out2,
  output logic [size-1:0] out3,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic            busy
`ifdef DEMUX_STATS_EN
  ,
  output logic [31:0]     stat_count,
  input  logic            stat_clr
`endif
);

  localparam int unsigned NCH      = 4;
  localparam int unsigned CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_EMPTY = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(2);

  logic [size-1:0]  r_head  [NCH];
  logic [size-1:0]  r_tail  [NCH];
  logic [CNT_W-1:0] r_count [NCH];

  logic [NCH-1:0]   w_push;
  logic [NCH-1:0]   w_pop;

  // Ready looks only at the selected channel's stored count, never at out_ready.
  always_comb begin
    in_ready = (r_count[in_select] != CNT_FULL);
  end

  // Per-channel push/pop strobes.
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      w_push[n] = in_valid && in_ready && (in_select == CNT_W'(n));
      w_pop[n]  = (r_count[n] != CNT_EMPTY) && out_ready[n];
    end
  end

  // FIFO state: head/tail/count per channel; full-with-push cannot occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        r_head[n]  <= '0;
        r_tail[n]  <= '0;
        r_count[n] <= CNT_EMPTY;
      end
    end else begin
      for (int unsigned n = 0; n < NCH; n++) begin
        case (r_count[n])
          CNT_EMPTY: begin
            if (w_push[n]) begin
              r_head[n]  <= in_data;
              r_count[n] <= CNT_ONE;
            end
          end
          CNT_ONE: begin
            if (w_push[n] && w_pop[n]) begin
              r_head[n] <= in_data;
            end else if (w_push[n]) begin
              r_tail[n]  <= in_data;
              r_count[n] <= CNT_FULL;
            end else if (w_pop[n]) begin
              r_count[n] <= CNT_EMPTY;
            end
          end
          CNT_FULL: begin
            if (w_pop[n]) begin
              r_head[n]  <= r_tail[n];
              r_count[n] <= CNT_ONE;
            end
          end
          default: begin
            r_count[n] <= r_count[n];
          end
        endcase
      end
    end
  end

  // Heads drive the outputs directly; valid/busy derive from counts only.
  always_comb begin
    out0 = r_head[0];
    out1 = r_head[1];
    out2 = r_head[2];
    out3 = r_head[3];
    out_valid = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      out_valid[n] = (r_count[n] != CNT_EMPTY);
    end
    busy = |out_valid;
  end

`ifdef DEMUX_STATS_EN
  localparam int unsigned STAT_W = 8;
  localparam logic [STAT_W-1:0] STAT_MAX = STAT_W'(255);

  logic [STAT_W-1:0] r_stat [NCH];

  // Saturating accept counters; clear wins over a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < NCH; n++) begin
        r_stat[n] <= '0;
      end
    end else begin
      for (int unsigned n = 0; n < NCH; n++) begin
        if (stat_clr) begin
          r_stat[n] <= '0;
        end else if (w_push[n] && (r_stat[n] != STAT_MAX)) begin
          r_stat[n] <= r_stat[n] + STAT_W'(1);
        end
      end
    end
  end

  // Pack channel n into bits [8n+7:8n].
  always_comb begin
    stat_count = {r_stat[3], r_stat[2], r_stat[1], r_stat[0]};
  end
`endif

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Self-checking bench for demux_1to4_buf with a per-channel expected-word queue.
// Stats checks are included when DEMUX_STATS_EN is defined.
module tb_demux_1to4_buf;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic [1:0]  in_select;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0, out1, out2, out3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        busy;
`ifdef DEMUX_STATS_EN
  logic [31:0] stat_count;
  logic        stat_clr;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q [4][$];

  demux_1to4_buf #(.size(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_select (in_select),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef DEMUX_STATS_EN
    ,
    .stat_count(stat_count),
    .stat_clr  (stat_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] out_of(input int n);
    case (n)
      0: return out0;
      1: return out1;
      2: return out2;
      default: return out3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    for (int n = 0; n < 4; n++) exp_q[n].delete();
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d);
    in_valid  = v;
    in_select = s;
    in_data   = d;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b busy=%b, expected 0000/0", out_valid, busy);
    end
    checks++;
    if ({out0, out1, out2, out3} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: outs=%h %h %h %h, expected all 0", out0, out1, out2, out3);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b, expected 1", in_ready);
    end
  endtask

  task automatic test_routing();
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    out_ready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(1'b1, 2'(i), words[i]);
      else       drive(1'b0, 2'd0, 16'h0);
      if (i > 0) begin
        checks++;
        if (out_valid !== (4'b0001 << (i - 1))) begin
          errors++;
          $display("FAIL routing_valid%0d: out_valid=%b, expected %b", i - 1, out_valid, 4'b0001 << (i - 1));
        end
        checks++;
        if (out_of(i - 1) !== exp_q[i - 1][0]) begin
          errors++;
          $display("FAIL routing_data%0d: got %h, expected %h", i - 1, out_of(i - 1), exp_q[i - 1][0]);
        end
        void'(exp_q[i - 1].pop_front());
      end
      if (i < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL routing_ready%0d: in_ready=%b, expected 1", i, in_ready);
        end
        exp_q[i].push_back(words[i]);
      end
      step();
    end
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL routing_drained: out_valid=%b busy=%b, expected 0000/0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1101;
    drive(1'b1, 2'd1, 16'hA001);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: in_ready=%b, expected 1", in_ready); end
    exp_q[1].push_back(16'hA001);
    step();
    drive(1'b1, 2'd1, 16'hA002);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept2: in_ready=%b, expected 1", in_ready); end
    exp_q[1].push_back(16'hA002);
    step();
    drive(1'b1, 2'd1, 16'hA003);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%b, expected 0", in_ready); end
    step();
    checks++;
    if (in_ready !== 1'b0 || out1 !== 16'hA001) begin
      errors++;
      $display("FAIL bp_stall: in_ready=%b out1=%h, expected 0/a001", in_ready, out1);
    end
    out_ready = 4'hF;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_no_bypass: in_ready=%b, expected 0", in_ready); end
    checks++;
    if (out1 !== exp_q[1][0]) begin errors++; $display("FAIL bp_head1: out1=%h, expected %h", out1, exp_q[1][0]); end
    void'(exp_q[1].pop_front());
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept3: in_ready=%b, expected 1", in_ready); end
    checks++;
    if (out1 !== exp_q[1][0]) begin errors++; $display("FAIL bp_head2: out1=%h, expected %h", out1, exp_q[1][0]); end
    void'(exp_q[1].pop_front());
    exp_q[1].push_back(16'hA003);
    step();
    drive(1'b0, 2'd1, 16'h0);
    checks++;
    if (out1 !== exp_q[1][0] || out_valid !== 4'b0010) begin
      errors++;
      $display("FAIL bp_head3: out1=%h out_valid=%b, expected %h/0010", out1, out_valid, exp_q[1][0]);
    end
    void'(exp_q[1].pop_front());
    step();
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL bp_drained: out_valid=%b, expected 0000", out_valid); end
  endtask

  task automatic test_independence();
    out_ready = 4'b0000;
    drive(1'b1, 2'd0, 16'hC001); exp_q[0].push_back(16'hC001); step();
    drive(1'b1, 2'd0, 16'hC002); exp_q[0].push_back(16'hC002); step();
    drive(1'b1, 2'd0, 16'hC003);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ind_ch0_full: in_ready=%b, expected 0", in_ready); end
    drive(1'b1, 2'd3, 16'h0BEE);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ind_ch3_ready: in_ready=%b, expected 1", in_ready); end
    exp_q[3].push_back(16'h0BEE);
    step();
    drive(1'b0, 2'd0, 16'h0);
    checks++;
    if (out3 !== 16'h0BEE || out0 !== 16'hC001 || out_valid !== 4'b1001) begin
      errors++;
      $display("FAIL ind_outputs: out3=%h out0=%h out_valid=%b, expected 0bee/c001/1001", out3, out0, out_valid);
    end
    out_ready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int n = 0; n < 4; n++) begin
        if (exp_q[n].size() != 0) begin
          checks++;
          if (out_of(n) !== exp_q[n][0]) begin
            errors++;
            $display("FAIL ind_drain ch%0d: got %h, expected %h", n, out_of(n), exp_q[n][0]);
          end
          void'(exp_q[n].pop_front());
        end
      end
      step();
    end
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL ind_drained: out_valid=%b, expected 0000", out_valid); end
  endtask

  task automatic test_push_pop();
    out_ready = 4'b0000;
    drive(1'b1, 2'd2, 16'h5555); step();
    drive(1'b0, 2'd2, 16'h0);
    checks++;
    if (out2 !== 16'h5555 || out_valid !== 4'b0100) begin
      errors++;
      $display("FAIL pp_setup: out2=%h out_valid=%b, expected 5555/0100", out2, out_valid);
    end
    out_ready = 4'b0100;
    drive(1'b1, 2'd2, 16'h6666);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL pp_ready: in_ready=%b, expected 1", in_ready); end
    step();
    out_ready = 4'b0000;
    drive(1'b0, 2'd2, 16'h0);
    checks++;
    if (out2 !== 16'h6666 || out_valid !== 4'b0100) begin
      errors++;
      $display("FAIL pp_result: out2=%h out_valid=%b, expected 6666/0100", out2, out_valid);
    end
    drive(1'b1, 2'd2, 16'h7777); step();
    drive(1'b0, 2'd2, 16'h0);
    checks++;
    if (in_ready !== 1'b0 || out2 !== 16'h6666) begin
      errors++;
      $display("FAIL pp_count: in_ready=%b out2=%h, expected 0/6666 (count 2)", in_ready, out2);
    end
    out_ready = 4'b0100;
    step();
    checks++;
    if (out2 !== 16'h7777) begin errors++; $display("FAIL pp_tail: out2=%h, expected 7777", out2); end
    step();
    out_ready = 4'b0000;
    checks++;
    if (out_valid !== 4'b0000) begin errors++; $display("FAIL pp_drained: out_valid=%b, expected 0000", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic       v;
    logic [1:0] s;
    logic       exp_ready;
    for (int c = 0; c < 300; c++) begin
      v = 1'($urandom_range(0, 3) != 0);
      s = 2'($urandom_range(0, 3));
      out_ready = 4'($urandom);
      drive(v, s, 16'($urandom));
      exp_ready = (exp_q[s].size() != 2);
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL b2b_ready c%0d: in_ready=%b, expected %b", c, in_ready, exp_ready);
      end
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (out_valid[n] !== (exp_q[n].size() != 0)) begin
          errors++;
          $display("FAIL b2b_valid c%0d ch%0d: out_valid=%b, expected %0d entries", c, n, out_valid[n], exp_q[n].size());
        end else if (exp_q[n].size() != 0) begin
          if (out_of(n) !== exp_q[n][0]) begin
            errors++;
            $display("FAIL b2b_data c%0d ch%0d: got %h, expected %h", c, n, out_of(n), exp_q[n][0]);
          end
          if (out_ready[n]) void'(exp_q[n].pop_front());
        end
      end
      if (v && exp_ready) exp_q[s].push_back(in_data);
      step();
    end
    drive(1'b0, 2'd0, 16'h0);
    out_ready = 4'hF;
    step(); step(); step();
    clear_queues();
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: out_valid=%b busy=%b, expected 0000/0", out_valid, busy);
    end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_stats();
    logic [23:0] others;
    out_ready = 4'hF;
    others = stat_count[31:8];
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd0, 16'(i));
      step();
    end
    drive(1'b0, 2'd0, 16'h0);
    step();
    clear_queues();
    checks++;
    if (stat_count[7:0] !== 8'd255) begin
      errors++;
      $display("FAIL stats_sat: field0=%0d, expected 255", stat_count[7:0]);
    end
    checks++;
    if (stat_count[31:8] !== others) begin
      errors++;
      $display("FAIL stats_others: fields=%h, expected %h", stat_count[31:8], others);
    end
    stat_clr = 1'b1;
    drive(1'b1, 2'd1, 16'h1234);
    step();
    stat_clr = 1'b0;
    drive(1'b0, 2'd0, 16'h0);
    checks++;
    if (stat_count !== 32'h0) begin
      errors++;
      $display("FAIL stats_clr: stat_count=%h, expected 0", stat_count);
    end
    drive(1'b1, 2'd3, 16'h4321);
    step();
    drive(1'b0, 2'd0, 16'h0);
    step();
    checks++;
    if (stat_count !== 32'h0100_0000) begin
      errors++;
      $display("FAIL stats_count3: stat_count=%h, expected 01000000", stat_count);
    end
  endtask
`endif

  task automatic test_reset_mid();
    out_ready = 4'b0000;
    drive(1'b1, 2'd2, 16'hD001); step();
    drive(1'b1, 2'd2, 16'hD002); step();
    checks++;
    if (out_valid !== 4'b0100 || out2 !== 16'hD001) begin
      errors++;
      $display("FAIL rstmid_setup: out_valid=%b out2=%h, expected 0100/d001", out_valid, out2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out2 !== 16'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: out_valid=%b out2=%h busy=%b, expected 0000/0000/0", out_valid, out2, busy);
    end
    clear_queues();
    drive(1'b0, 2'd0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(1'b1, 2'd2, 16'hE001);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: in_ready=%b, expected 1", in_ready); end
    step();
    drive(1'b0, 2'd0, 16'h0);
    checks++;
    if (out2 !== 16'hE001 || out_valid !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_resume: out2=%h out_valid=%b, expected e001/0100", out2, out_valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_select = '0;
    in_valid  = 1'b0;
    out_ready = '0;
`ifdef DEMUX_STATS_EN
    stat_clr  = 1'b0;
`endif
    clear_queues();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_routing();
    test_backpressure();
    test_independence();
    test_push_pop();
    test_back_to_back();
`ifdef DEMUX_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
